cpu_issuer: RTL and testbench

- Instruction initiator for the lab CPU's external handshake (clk, reset, s, load, in, out, N, V, Z, w).
- Buffers 16-bit instructions pushed by a host in a small FIFO and issues them to the CPU one at a time: load, start pulse, wait for the w handshake.
- After each instruction it captures the CPU's out and N/V/Z status and returns them to the host.
- Sits between a host/sequencer (or bench) and the cpu top level; replaces hand-driven s/load stimulus.

---
 rtl/cpu_issuer_pkg.sv | 19 +
 rtl/issuer_fifo.sv | 48 ++++
 rtl/cpu_issuer.sv | 107 ++++++++++
 tb/tb_cpu_issuer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_issuer_pkg.sv
// Shared definitions for the CPU instruction issuer: FSM encoding and
// opcode fields (opcode[15:13] + op[12:11]) of the lab CPU instruction set.
package cpu_issuer_pkg;
  localparam int IW = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [4:0] MOV_IMM = 5'b11010;
  localparam logic [4:0] MOV_REG = 5'b11000;
  localparam logic [4:0] ADD     = 5'b10100;
  localparam logic [4:0] CMP     = 5'b10101;
  localparam logic [4:0] AND     = 5'b10110;
  localparam logic [4:0] MVN     = 5'b10111;
endpackage

// File: rtl/issuer_fifo.sv
// Instruction FIFO: DEPTH x W, first-word-fall-through head, full/empty flags.
module issuer_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          wr, rd;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/cpu_issuer.sv
// Issues queued 16-bit instructions to the lab CPU via load/s/w handshake
// and returns the CPU's out value and {N,V,Z} flags per instruction.
module cpu_issuer
  import cpu_issuer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_valid,
  input  logic [IW-1:0] push_instr,
  output logic          push_ready,
  output logic [IW-1:0] cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  input  logic          cpu_w,
  input  logic [IW-1:0] cpu_out,
  input  logic [2:0]    cpu_nvz,
  output logic          res_valid,
  output logic [IW-1:0] res_data,
  output logic [2:0]    res_nvz,
  output logic          busy,
  output logic          err,
  output logic [7:0]    issued_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  logic [2:0]    state, state_n;
  logic [TW-1:0] timer;
  logic          full, empty, pop, tmo, waiting;
  logic [IW-1:0] head;

  issuer_fifo #(.DEPTH(DEPTH), .W(IW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_valid),
    .pop   (pop),
    .wdata (push_instr),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign push_ready = !full;
  assign busy       = (state != S_IDLE) || !empty;
  assign pop        = (state == S_IDLE) && !empty && cpu_w;
  assign waiting    = (state == S_WAIT_LO) || (state == S_WAIT_HI);

  always_comb begin
    state_n = state;
    tmo     = 1'b0;
    case (state)
      S_IDLE:  if (pop) state_n = S_LOAD;
      S_LOAD:  state_n = S_START;
      S_START: state_n = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!cpu_w) state_n = S_WAIT_HI;
        else if (timer == TLIM) begin
          state_n = S_IDLE;
          tmo     = 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (cpu_w) state_n = S_DONE;
        else if (timer == TLIM) begin
          state_n = S_IDLE;
          tmo     = 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // timer is 0 in START and counts up through the wait states, so a timeout
  // lands TIMEOUT cycles after the s pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      cpu_in     <= '0;
      cpu_load   <= 1'b0;
      cpu_s      <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_nvz    <= '0;
      err        <= 1'b0;
      issued_cnt <= '0;
    end else begin
      state     <= state_n;
      cpu_load  <= (state_n == S_LOAD);
      cpu_s     <= (state_n == S_START);
      res_valid <= (state == S_DONE);
      if (pop) cpu_in <= head;
      if (state_n == S_START)              timer <= '0;
      else if (state == S_START || waiting) timer <= timer + 1'b1;
      if (tmo) err <= 1'b1;
      if (state == S_DONE) begin
        res_data   <= cpu_out;
        res_nvz    <= cpu_nvz;
        issued_cnt <= issued_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cpu_issuer.sv
// Directed bench for cpu_issuer with a behavioural lab-CPU model that can
// also act as a stuck-busy or never-starting stub.
module tb_cpu_issuer;
  import cpu_issuer_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clk, reset;
  logic        push_valid;
  logic [15:0] push_instr;
  logic        push_ready;
  logic [15:0] cpu_in;
  logic        cpu_load, cpu_s, cpu_w;
  logic [15:0] cpu_out;
  logic [2:0]  cpu_nvz;
  logic        res_valid;
  logic [15:0] res_data;
  logic [2:0]  res_nvz;
  logic        busy, err;
  logic [7:0]  issued_cnt;

  int checks = 0;
  int errors = 0;

  cpu_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .push_valid(push_valid), .push_instr(push_instr),
    .push_ready(push_ready), .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_s(cpu_s),
    .cpu_w(cpu_w), .cpu_out(cpu_out), .cpu_nvz(cpu_nvz), .res_valid(res_valid),
    .res_data(res_data), .res_nvz(res_nvz), .busy(busy), .err(err),
    .issued_cnt(issued_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // CPU model: mode 0 = executes in 3 cycles, 1 = w held low, 2 = w held high
  int          mode = 0;
  logic [15:0] regs [8];
  logic [15:0] ir;
  logic [2:0]  flags;
  int          xcnt;
  logic [15:0] ex_a, ex_b, ex_r;
  logic [2:0]  ex_dst;

  function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] sh);
    case (sh)
      2'b01:   return {v[14:0], 1'b0};
      2'b10:   return {1'b0, v[15:1]};
      2'b11:   return {v[15], v[15:1]};
      default: return v;
    endcase
  endfunction

  always_comb begin
    ex_a   = regs[ir[10:8]];
    ex_b   = shf(regs[ir[2:0]], ir[4:3]);
    ex_dst = ir[7:5];
    ex_r   = 16'h0;
    case (ir[15:11])
      MOV_IMM: begin ex_r = {{8{ir[7]}}, ir[7:0]}; ex_dst = ir[10:8]; end
      MOV_REG: ex_r = ex_b;
      ADD:     ex_r = ex_a + ex_b;
      CMP:     ex_r = ex_a - ex_b;
      AND:     ex_r = ex_a & ex_b;
      MVN:     ex_r = ~ex_b;
      default: ex_r = 16'h0;
    endcase
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_w   <= 1'b1;
      xcnt    <= 0;
      ir      <= '0;
      flags   <= '0;
      cpu_out <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (cpu_load) ir <= cpu_in;
      if (mode == 1) cpu_w <= 1'b0;
      else if (mode == 2) cpu_w <= 1'b1;
      else if (cpu_w) begin
        if (cpu_s) begin cpu_w <= 1'b0; xcnt <= 3; end
      end else if (xcnt > 1) xcnt <= xcnt - 1;
      else begin
        if (xcnt == 1) begin
          cpu_out <= ex_r;
          if (ir[15:11] == CMP)
            flags <= {ex_r[15], (ex_a[15] != ex_b[15]) && (ex_r[15] != ex_a[15]), ex_r == 16'h0};
          else if (ir[15:11] != 5'b0)
            regs[ex_dst] <= ex_r;
        end
        cpu_w <= 1'b1;
        xcnt  <= 0;
      end
    end
  end
  assign cpu_nvz = flags;

  // Monitors, sampled on the falling edge
  int          cyc = 0;
  int          load_cnt = 0, s_cnt = 0, res_cnt = 0, in_bad = 0, both_bad = 0;
  int          last_s = 0, err_delta = -1;
  logic        err_q = 1'b0;
  logic [15:0] lat_in = '0;
  logic [18:0] res_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cpu_load) begin load_cnt <= load_cnt + 1; lat_in <= cpu_in; end
    if (cpu_s) begin
      s_cnt  <= s_cnt + 1;
      last_s <= cyc;
      if (cpu_in !== lat_in) in_bad <= in_bad + 1;
    end
    if (cpu_load && cpu_s) both_bad <= both_bad + 1;
    if (res_valid) begin res_cnt <= res_cnt + 1; res_q.push_back({res_nvz, res_data}); end
    if (err && !err_q) err_delta <= cyc - last_s;
    err_q <= err;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mov_i(input logic [2:0] rn, input logic [7:0] im);
    return {MOV_IMM, rn, im};
  endfunction
  function automatic logic [15:0] mov_r(input logic [2:0] rd, input logic [1:0] sh, input logic [2:0] rm);
    return {MOV_REG, 3'b000, rd, sh, rm};
  endfunction
  function automatic logic [15:0] alu(input logic [4:0] op, input logic [2:0] rn, input logic [2:0] rd,
                                      input logic [2:0] rm);
    return {op, rn, rd, 2'b00, rm};
  endfunction

  task automatic push_try(input logic [15:0] w, output logic acc);
    push_valid = 1'b1;
    push_instr = w;
    acc        = push_ready;
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] w);
    logic acc;
    int   n = 0;
    @(negedge clk);
    while (!push_ready && n < 200) begin @(negedge clk); n++; end
    push_try(w, acc);
    push_valid = 1'b0;
    chk("push_accept", acc, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin @(negedge clk); n++; end
    chk("idle_reached", busy, 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  int b_res, b_s, b_load, n;
  logic acc;
  int accepted;

  initial begin
    reset      = 1'b0;
    push_valid = 1'b0;
    push_instr = '0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_in", cpu_in, 0);
    chk("rst_cpu_load", cpu_load, 0);
    chk("rst_cpu_s", cpu_s, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_nvz", res_nvz, 0);
    chk("rst_err", err, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_push_ready", push_ready, 1);

    // single MOV R0,#0x69
    b_res = res_cnt; b_s = s_cnt; b_load = load_cnt;
    push(16'b11010_000_01101001);
    wait_idle();
    chk("t1_load_pulses", load_cnt - b_load, 1);
    chk("t1_s_pulses", s_cnt - b_s, 1);
    chk("t1_res_pulses", res_cnt - b_res, 1);
    chk("t1_r0", res_q[b_res][15:0], 16'h0069);
    chk("t1_issued", issued_cnt, 1);

    // reset in the middle of an instruction with one more queued
    push(mov_i(3'd1, 8'd5));
    push(mov_i(3'd2, 8'd6));
    n = 0;
    while (s_cnt == b_s + 1 && n < 100) begin @(negedge clk); n++; end
    chk("mr_s_seen", s_cnt - b_s, 2);
    reset = 1'b0;
    #1;
    chk("mr_cpu_s", cpu_s, 0);
    chk("mr_cpu_load", cpu_load, 0);
    chk("mr_cpu_in", cpu_in, 0);
    chk("mr_busy", busy, 0);
    chk("mr_issued", issued_cnt, 0);
    chk("mr_res_valid", res_valid, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    b_s = s_cnt; b_res = res_cnt;
    @(negedge clk);
    chk("mr_push_ready", push_ready, 1);
    repeat (40) @(negedge clk);
    chk("mr_no_s", s_cnt - b_s, 0);
    chk("mr_no_res", res_cnt - b_res, 0);

    // back-to-back MOV, MOV, ADD
    b_res = res_cnt;
    push(mov_i(3'd0, 8'd8));
    push(mov_i(3'd1, 8'd4));
    push(alu(ADD, 3'd0, 3'd2, 3'd1));
    wait_idle();
    chk("t3_res_pulses", res_cnt - b_res, 3);
    chk("t3_r0", res_q[b_res][15:0], 16'h0008);
    chk("t3_r1", res_q[b_res+1][15:0], 16'h0004);
    chk("t3_r2", res_q[b_res+2][15:0], 16'h000C);
    chk("t3_issued", issued_cnt, 3);
    chk("t3_busy", busy, 0);

    // CMP overflow case and CMP equal
    b_res = res_cnt;
    push(mov_i(3'd4, 8'hFF));
    push(mov_r(3'd4, 2'b10, 3'd4));
    push(mov_i(3'd5, 8'hF7));
    push(alu(CMP, 3'd5, 3'd0, 3'd4));
    push(alu(CMP, 3'd5, 3'd0, 3'd5));
    wait_idle();
    chk("t5_res_pulses", res_cnt - b_res, 5);
    chk("t5_r4", res_q[b_res+1][15:0], 16'h7FFF);
    chk("t5_r5", res_q[b_res+2][15:0], 16'hFFF7);
    chk("t5_nvz_pre", res_q[b_res+2][18:16], 3'b000);
    chk("t5_cmp_ovf", res_q[b_res+3][18:16], 3'b010);
    chk("t5_cmp_eq", res_q[b_res+4][18:16], 3'b001);
    chk("t5_issued", issued_cnt, 8);

    // FIFO full while the CPU stub holds w low
    mode = 1;
    @(negedge clk);
    @(negedge clk);
    b_res = res_cnt; b_s = s_cnt;
    accepted = 0;
    for (int i = 1; i <= DEPTH + 2; i++) begin
      push_try(mov_i(3'd0, 8'(i)), acc);
      if (acc) accepted++;
    end
    push_valid = 1'b0;
    chk("full_accepted", accepted, DEPTH);
    chk("full_ready", push_ready, 0);
    chk("full_busy", busy, 1);
    chk("full_no_issue", s_cnt - b_s, 0);
    mode = 0;
    wait_idle();
    chk("full_res_pulses", res_cnt - b_res, DEPTH);
    chk("full_first", res_q[b_res][15:0], 16'h0001);
    chk("full_last", res_q[b_res+DEPTH-1][15:0], 16'(DEPTH));
    chk("full_issued", issued_cnt, 12);

    // timeout: stub never drops w; the next queued instruction still issues
    mode = 2;
    @(negedge clk);
    b_res = res_cnt; b_s = s_cnt;
    push(mov_i(3'd6, 8'h11));
    push(mov_i(3'd7, 8'h22));
    n = 0;
    while (!err && n < 300) begin @(negedge clk); n++; end
    mode = 0;
    chk("to_err", err, 1);
    #1;
    chk("to_delay", err_delta, TIMEOUT);
    chk("to_no_res", res_cnt - b_res, 0);
    chk("to_issued_hold", issued_cnt, 12);
    wait_idle();
    chk("to_next_res", res_cnt - b_res, 1);
    chk("to_next_data", res_q[b_res][15:0], 16'h0022);
    chk("to_next_s", s_cnt - b_s, 2);
    chk("to_issued", issued_cnt, 13);
    chk("to_err_sticky", err, 1);

    chk("cpu_in_stable", in_bad, 0);
    chk("load_s_exclusive", both_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
